// File: rtl/gray_pkg.sv
// gray_pkg: shared width default, FSM state type and Gray-code helper for the pointer receiver.
//   GRAY_N      default pointer width
//   state_t     receiver FSM states {WARMUP, RUN}
//   hamming_gt1 true when more than one bit of an XOR vector is set
package gray_pkg;
   localparam int GRAY_N = 8;
   typedef enum logic {WARMUP, RUN} state_t;
   // Clearing the lowest set bit leaves a non-zero value only if two or more bits were set.
   function automatic logic hamming_gt1(input logic [63:0] x);
      return (x & (x - 64'd1)) != 64'd0;
   endfunction
endpackage

// File: rtl/gray_ptr_sync_if.sv
// gray_ptr_sync_if: pointer-crossing bundle between the remote side and the receiver.
//   GI       Gray pointer from the remote clock domain
//   LOCAL_BI local binary pointer
//   BO       synchronized, decoded pointer
//   DIFF     LOCAL_BI - BO modulo 2^N
//   CHG      one-cycle pulse on a new BO value
//   ERR      sticky multi-bit-change flag
interface gray_ptr_sync_if #(parameter int N = gray_pkg::GRAY_N);
   logic [N-1:0] GI;
   logic [N-1:0] LOCAL_BI;
   logic [N-1:0] BO;
   logic [N-1:0] DIFF;
   logic         CHG;
   logic         ERR;
   modport master (output GI, LOCAL_BI, input BO, DIFF, CHG, ERR);
   modport slave  (input GI, LOCAL_BI, output BO, DIFF, CHG, ERR);
endinterface

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary decoder.
//   gray in  N-bit Gray code
//   bin  out N-bit binary value
module gray2bin #(parameter int N = 8) (
   input  logic [N-1:0] gray,
   output logic [N-1:0] bin
);
   // Each binary bit is the parity of all Gray bits at or above it.
   for (genvar i = 0; i < N; i++) begin : g_bit
      assign bin[i] = ^gray[N-1:i];
   end
endmodule

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: destination-domain receiver for a Gray pointer crossing from a remote clock.
//   CLK  destination clock
//   RST  asynchronous active-high reset
//   bus  slave side of gray_ptr_sync_if (GI, LOCAL_BI in; BO, DIFF, CHG, ERR out)
// Optional feature: define GRAY_SYNC_CHECK_EN to build the multi-bit-change detector driving ERR;
// otherwise ERR is tied low.
module gray_ptr_sync import gray_pkg::*; #(
   parameter int N           = GRAY_N,
   parameter int SYNC_STAGES = 2
) (
   input  logic         CLK,
   input  logic         RST,
   gray_ptr_sync_if.slave bus
);
   localparam int CW = $clog2(SYNC_STAGES + 2);
   logic [N-1:0]  sync [SYNC_STAGES];
   logic [N-1:0]  dec;
   logic [N-1:0]  bo;
   logic [N-1:0]  diff;
   logic [N-1:0]  diff_n;
   logic          chg;
   logic          chg_n;
   logic          run;
   logic [CW-1:0] cnt;
   state_t        state;
   state_t        state_n;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      end else begin
         sync[0] <= bus.GI;
         for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      end
   end
   gray2bin #(.N(N)) u_dec (.gray(sync[SYNC_STAGES-1]), .bin(dec));
   // The counter tracks edges since reset release; it freezes once RUN is reached.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= WARMUP;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= (state == WARMUP) ? cnt + 1'b1 : cnt;
      end
   end
   // RUN is entered on the edge where the count reaches SYNC_STAGES+1, i.e. once the chain holds real samples.
   always_comb begin
      state_n = (state == WARMUP && cnt == CW'(SYNC_STAGES)) ? RUN : state;
   end
   always_comb begin
      run    = state == RUN;
      chg_n  = run && (dec != bo);
      diff_n = bus.LOCAL_BI - dec;
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         bo   <= '0;
         diff <= '0;
         chg  <= 1'b0;
      end else begin
         bo   <= dec;
         diff <= diff_n;
         chg  <= chg_n;
      end
   end
`ifdef GRAY_SYNC_CHECK_EN
   logic [N-1:0] prev;
   logic         err;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         prev <= '0;
         err  <= 1'b0;
      end else begin
         prev <= sync[SYNC_STAGES-1];
         err  <= err | (run && hamming_gt1(64'(sync[SYNC_STAGES-1] ^ prev)));
      end
   end
   assign bus.ERR = err;
`else
   assign bus.ERR = 1'b0;
`endif
   assign bus.BO   = bo;
   assign bus.DIFF = diff;
   assign bus.CHG  = chg;
endmodule

// File: tb/tb_gray_ptr_sync.sv
// tb_gray_ptr_sync: directed self-checking bench for gray_ptr_sync (N=8, SYNC_STAGES=2).
module tb_gray_ptr_sync;
   import gray_pkg::*;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   checks = 0;
   int   errors = 0;
`ifdef GRAY_SYNC_CHECK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif
   gray_ptr_sync_if #(.N(8)) bus ();
   gray_ptr_sync #(.N(8), .SYNC_STAGES(2)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));
   always #5 CLK = ~CLK;
   initial begin
      #100000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask
   task automatic outs(input string tag, input logic [7:0] bo, input logic [7:0] diff, input logic chg);
      chk({tag, ".bo"}, 32'(bus.BO), 32'(bo));
      chk({tag, ".diff"}, 32'(bus.DIFF), 32'(diff));
      chk({tag, ".chg"}, 32'(bus.CHG), 32'(chg));
   endtask
   logic [7:0] steps [5] = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07};
   initial begin
      bus.GI = 8'h00;
      bus.LOCAL_BI = 8'h00;
      tick(2);
      outs("rst", 8'h00, 8'h00, 1'b0);
      chk("rst.err", 32'(bus.ERR), 32'd0);
      RST = 1'b0;
      tick(1);
      chk("wu1.state", 32'(dut.state), 32'(WARMUP));
      chk("wu1.chg", 32'(bus.CHG), 32'd0);
      tick(1);
      chk("wu2.state", 32'(dut.state), 32'(WARMUP));
      chk("wu2.chg", 32'(bus.CHG), 32'd0);
      tick(1);
      chk("wu3.state", 32'(dut.state), 32'(RUN));
      outs("wu3", 8'h00, 8'h00, 1'b0);
      bus.LOCAL_BI = 8'h08;
      tick(1);
      chk("lbi.diff", 32'(bus.DIFF), 32'h08);
      for (int k = 0; k < 5; k++) begin
         bus.GI = steps[k];
         tick(2);
         chk("step.hold", 32'(bus.BO), 32'(k));
         chk("step.nochg", 32'(bus.CHG), 32'd0);
         tick(1);
         outs("step", 8'(k + 1), 8'(7 - k), 1'b1);
         tick(1);
         chk("step.pulse", 32'(bus.CHG), 32'd0);
      end
      @(posedge CLK);
      #2 RST = 1'b1;
      #1 outs("arst", 8'h00, 8'h00, 1'b0);
      chk("arst.err", 32'(bus.ERR), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      tick(2);
      chk("rel.hold", 32'(bus.BO), 32'h00);
      tick(1);
      outs("rel", 8'h05, 8'h03, 1'b0);
      chk("rel.state", 32'(dut.state), 32'(RUN));
      tick(1);
      chk("rel.chg", 32'(bus.CHG), 32'd0);
      bus.GI = 8'h03;
      bus.LOCAL_BI = 8'h05;
      tick(4);
      outs("pre6", 8'h02, 8'h03, 1'b0);
      bus.GI = 8'h02;
      bus.LOCAL_BI = 8'h06;
      tick(1);
      outs("sim1", 8'h02, 8'h04, 1'b0);
      tick(2);
      outs("sim3", 8'h03, 8'h03, 1'b1);
      RST = 1'b1;
      bus.GI = 8'h00;
      bus.LOCAL_BI = 8'h02;
      tick(1);
      RST = 1'b0;
      tick(3);
      outs("wrap0", 8'h00, 8'h02, 1'b0);
      bus.GI = 8'h80;
      tick(3);
      outs("wrapff", 8'hFF, 8'h03, 1'b1);
      tick(1);
      chk("wrapff.pulse", 32'(bus.CHG), 32'd0);
      bus.GI = 8'h00;
      tick(3);
      outs("wrap00", 8'h00, 8'h02, 1'b1);
      chk("wrap.err", 32'(bus.ERR), 32'd0);
      bus.GI = 8'h03;
      tick(3);
      outs("multi", 8'h02, 8'h00, 1'b1);
      chk("multi.err", 32'(bus.ERR), 32'(ERR_EXP));
      bus.GI = 8'h01;
      tick(4);
      chk("sticky.bo", 32'(bus.BO), 32'h01);
      chk("sticky.err", 32'(bus.ERR), 32'(ERR_EXP));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
